tt_um_vedic_div_8x4: RTL
========================

# tt_um_vedic_div_8x4

Sequential 8-bit by 4-bit unsigned restoring divider packaged as a TinyTapeout user module, the inverse companion of the team's 4x4 Vedic multiplier tile. It takes an 8-bit dividend on `ui_in` and a 4-bit divisor on `uio_in`, then computes one quotient bit per cycle under a start/busy/done handshake. Quotient or remainder appears on `uo_out`, and status appears on the upper bidirectional pins. Operands satisfy `dividend == quotient*divisor + remainder`, so multiplier products can be checked by round trip.

## Interface
- `DW`, default 8: dividend and quotient width.
- `VW`, default 4: divisor and remainder width.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: tile enable. When low, all state registers hold.
- `ui_in` in 8: dividend.
- `uio_in` in 8: bits [3:0] divisor, [4] start, [5] result select (0 selects quotient, 1 selects remainder). Bits [7:6] are ignored.
- `uo_out` out 8: when select is 0, quotient. When select is 1, `{4'b0, remainder}`. Combinational mux of registered results.
- `uio_out` out 8: [5] busy, [6] done, [7] div_by_zero, [4:0] tied 0.
- `uio_oe` out 8: constant `8'b1110_0000`.

## Operation
- States:
  - IDLE is the reset state.
  - RUN iterates.
  - DONE holds the results.
- Launch: a start rising edge, meaning `uio_in[4]` is 1 and its registered previous value `start_q` is 0, while in IDLE or DONE.
  - On the launch edge, capture the dividend and the divisor.
  - Clear done and div_by_zero, and clear the quotient and remainder registers.
- Start edges during RUN are ignored. `start_q` still updates.
- Divisor 0 at launch: go directly to DONE. Quotient = 8'hFF, remainder = 4'h0, div_by_zero = 1.
- Non-zero divisor: go to RUN with step count 0.
  - Each RUN cycle does one restoring step.
  - The partial remainder is 5 bits: `{rem[3:0], dividend MSB}`.
  - If it is ≥ the divisor, subtract the divisor and shift 1 into the quotient. Otherwise shift 0.
  - The dividend shifts left by 1.
- After 8 steps (count 7 → done), go to DONE.
- DONE: results, done and div_by_zero hold until the next launch. A launch from DONE is the only exit besides reset.
- busy = 1 exactly while in RUN.
- `ena` = 0: the FSM, counter, operand registers and `start_q` all freeze. Outputs keep their current values. A start edge that occurs while `ena` is 0 is lost.
- Reset mid-RUN: state goes immediately to IDLE and all registers clear. No partial result is visible.

## Timing
- Reset values:
  - `uo_out` = 0.
  - `uio_out` = 0 (busy, done and div_by_zero all 0).
  - `uio_oe` = 8'hE0.
  - `start_q` = 0.
  - Quotient and remainder registers = 0.
- Launch edge = T0.
  - busy rises after T0.
  - The final step occurs at T8. busy falls and done rises after T8, so results are valid 8 cycles after launch.
- Divide by zero: done and div_by_zero rise after T0 and busy never asserts. Results are valid 1 cycle after launch.
- Relaunch from DONE at edge T0: done falls after T0, in the same cycle busy rises.
- The select pin takes effect combinationally, with no latency.

## Structure
- Package `vedic_div_pkg`:
  - State enum `div_state_t`: IDLE, RUN, DONE.
  - Width constants `DW` and `VW`.
  - Step-counter width (3 bits).
  - Constants `DBZ_QUOT` = 8'hFF and `DBZ_REM` = 4'h0.
  - The `uio_oe` constant, plus the bit indices for start, select, busy, done and div_by_zero.
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: 4-bit remainder, incoming dividend bit, 4-bit divisor.
  - Outputs: next remainder, quotient bit.
- The top level holds the FSM, the edge detect, the registers and the output mux.

## Test plan
- 225 / 15: busy is high for 8 cycles, then done = 1. Select 0 gives `uo_out` = 15. Select 1 gives 0.
- 200 / 7: quotient 28, remainder 4, done exactly 8 cycles after the launch edge. 255 / 1: quotient 255, remainder 0.
- 5 / 9: quotient 0, remainder 5. Check the round trip `q*d + r == dividend` on a random sweep of 200 operand pairs.
- 77 / 0: done and div_by_zero rise 1 cycle after launch, busy is never high, quotient 0xFF, remainder 0.
- Edge cases:
  - Launch 100/3, then pulse start again at T3. The second pulse is ignored and the result is 33 r 1.
  - Holding start high after done must not relaunch.
  - Drop `ena` for 5 cycles mid-RUN. Completion is delayed by exactly 5 cycles and the result is unchanged.
- Assert `rst_n` = 0 at T4 of a run. All outputs go to 0 asynchronously and the state returns to IDLE. A fresh launch of 9 / 2 then gives 4 r 1.

Source files
------------

// File: rtl/vedic_div_pkg.sv
// vedic_div_pkg: shared types and constants for the 8x4 restoring divider tile
package vedic_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  localparam int DW = 8;
  localparam int VW = 4;
  localparam int CW = 3;
  localparam logic [DW-1:0] DBZ_QUOT = 8'hFF;
  localparam logic [VW-1:0] DBZ_REM = 4'h0;
  localparam logic [7:0] UIO_OE = 8'b1110_0000;
  localparam int START_BIT = 4;
  localparam int SEL_BIT = 5;
  localparam int BUSY_BIT = 5;
  localparam int DONE_BIT = 6;
  localparam int DBZ_BIT = 7;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
// rem: current remainder, din: next dividend bit, dvs: divisor
// rem_next: remainder after the trial subtract, q: resulting quotient bit
module div_step
  import vedic_div_pkg::*;
(
  input  logic [VW-1:0] rem,
  input  logic          din,
  input  logic [VW-1:0] dvs,
  output logic [VW-1:0] rem_next,
  output logic          q
);
  logic [VW:0] part;
  assign part = {rem, din};
  assign q = part >= {1'b0, dvs};
  // rem < dvs keeps part - dvs below dvs, so the difference always fits VW bits
  assign rem_next = q ? VW'(part - {1'b0, dvs}) : part[VW-1:0];
endmodule

// File: rtl/tt_um_vedic_div_8x4.sv
// tt_um_vedic_div_8x4: sequential 8-by-4 unsigned restoring divider tile
// ui_in: dividend; uio_in: [3:0] divisor, [4] start, [5] select (0 quotient, 1 remainder)
// uo_out: selected result; uio_out: [5] busy, [6] done, [7] div_by_zero; uio_oe: constant 8'hE0
module tt_um_vedic_div_8x4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import vedic_div_pkg::*;
  div_state_t state;
  logic start_q, dbz, launch, dvs_zero, q_bit;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd, quot;
  logic [VW-1:0] dvs, rem, rem_next;
  logic unused_pins;
  assign unused_pins = &{1'b0, uio_in[7:6]};
  assign launch = uio_in[START_BIT] && !start_q && state != RUN;
  assign dvs_zero = uio_in[VW-1:0] == '0;
  div_step u_step (
    .rem(rem),
    .din(dvd[DW-1]),
    .dvs(dvs),
    .rem_next(rem_next),
    .q(q_bit)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      start_q <= 1'b0;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      quot <= '0;
      rem <= '0;
      dbz <= 1'b0;
    end else if (ena) begin
      start_q <= uio_in[START_BIT];
      if (launch) begin
        dvd <= ui_in;
        dvs <= uio_in[VW-1:0];
        cnt <= '0;
        dbz <= dvs_zero;
        quot <= dvs_zero ? DBZ_QUOT : '0;
        rem <= dvs_zero ? DBZ_REM : '0;
        state <= dvs_zero ? DONE : RUN;
      end else if (state == RUN) begin
        rem <= rem_next;
        quot <= {quot[DW-2:0], q_bit};
        dvd <= dvd << 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DW - 1)) state <= DONE;
      end
    end
  end
  always_comb begin
    uio_out = '0;
    uio_out[BUSY_BIT] = state == RUN;
    uio_out[DONE_BIT] = state == DONE;
    uio_out[DBZ_BIT] = dbz;
  end
  assign uo_out = uio_in[SEL_BIT] ? {{(DW-VW){1'b0}}, rem} : quot;
  assign uio_oe = UIO_OE;
endmodule
